fnd_sum_display: RTL and testbench

Downstream stage of the 4-bit ripple-carry adder. Captures the adder's 5-bit result {carry, sum} (0..31) on a load strobe and splits it into tens and ones BCD digits. Drives a 4-digit multiplexed 7-segment (FND) display with a time-division scan. Sits between the adder datapath and the board's FND pins.

---
 rtl/fnd_pkg.sv | 22 ++
 rtl/bcd_to_seg.sv | 29 ++
 rtl/fnd_sum_display.sv | 124 ++++++++++++
 tb/tb_fnd_sum_display.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and types for the FND sum display
// Purpose: active-low 7-segment glyphs (bit0 = a .. bit6 = g), digit count
// and the digit-index type used by the scan logic.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low segment pattern
// Ports:
//   bcd  in   4-bit BCD digit; codes 10..15 produce a blank pattern
//   seg  out  7-bit active-low pattern, bit0 = a .. bit6 = g
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_sum_display.sv
// rtl/fnd_sum_display.sv - captures the adder result and scans it onto a 4-digit FND
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   i_load            captures {i_carry, i_sum} at the clock edge where it is high
//   i_sum, i_carry    adder result, carry has weight 16 (value 0..31)
//   i_en              display enable; low blanks every digit, scan keeps running
//   o_seg, o_dp       registered segments (bit0 = a .. bit6 = g), decimal point
//   o_com             registered digit commons, bit0 = ones digit, bit3 = leftmost
module fnd_sum_display
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_sum,
  input  logic       i_carry,
  input  logic       i_en,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [3:0] o_com
);

  localparam int                CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Inactive levels as seen on the pins for the selected board polarity.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [3:0] COM_OFF = SEG_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [4:0]       disp_val;
  logic [CNT_W-1:0] scan_cnt;
  digit_idx_t       digit_idx;

  logic [1:0] tens;
  logic [3:0] ones;
  logic [3:0] digit_bcd;
  logic [6:0] digit_pat;
  logic [6:0] seg_n;
  logic [3:0] com_n;
  logic [6:0] seg_next;
  logic [3:0] com_next;

  // Value never exceeds 31, so a three-threshold compare replaces a divider.
  always_comb begin
    tens = 2'd0;
    ones = disp_val[3:0];
    if (disp_val >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(disp_val - 5'd30);
    end else if (disp_val >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(disp_val - 5'd20);
    end else if (disp_val >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(disp_val - 5'd10);
    end
  end

  assign digit_bcd = (digit_idx == digit_idx_t'(1)) ? {2'b00, tens} : ones;

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit_bcd),
    .seg (digit_pat)
  );

  // Slot content in active-low terms; slots 2 and 3 stay dark so that the
  // per-digit refresh period is the same as on a fully populated display.
  always_comb begin
    seg_n = SEG_BLANK;
    com_n = 4'b1111;
    case (digit_idx)
      digit_idx_t'(0): begin
        seg_n = digit_pat;
        com_n = 4'b1110;
      end
      digit_idx_t'(1): begin
        if (!(LZ_BLANK && (tens == 2'd0))) begin
          seg_n = digit_pat;
          com_n = 4'b1101;
        end
      end
      default: begin
        seg_n = SEG_BLANK;
        com_n = 4'b1111;
      end
    endcase
    if (!i_en) begin
      seg_n = SEG_BLANK;
      com_n = 4'b1111;
    end
    seg_next = SEG_ACTIVE_LOW ? seg_n : ~seg_n;
    com_next = SEG_ACTIVE_LOW ? com_n : ~com_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_val  <= '0;
      scan_cnt  <= '0;
      digit_idx <= '0;
      o_seg     <= SEG_OFF;
      o_com     <= COM_OFF;
    end else begin
      if (i_load) begin
        disp_val <= {i_carry, i_sum};
      end
      if (scan_cnt == CNT_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == digit_idx_t'(NUM_DIGITS - 1)) ?
                     digit_idx_t'(0) : digit_idx_t'(digit_idx + 2'd1);
      end else begin
        scan_cnt <= CNT_W'(scan_cnt + CNT_W'(1));
      end
      o_seg <= seg_next;
      o_com <= com_next;
    end
  end

  assign o_dp = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_fnd_sum_display.sv
// tb/tb_fnd_sum_display.sv - scoreboard bench for fnd_sum_display in three configurations
module tb_fnd_sum_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_load;
  logic [3:0] i_sum;
  logic       i_carry;
  logic       i_en;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] com_a, com_b, com_c;
  logic       dp_a, dp_b, dp_c;

  always #5 clk = ~clk;

  // a: active-low, tens blanking; b: active-low, no blanking; c: active-high, tens blanking
  fnd_sum_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .i_load(i_load), .i_sum(i_sum), .i_carry(i_carry),
    .i_en(i_en), .o_seg(seg_a), .o_dp(dp_a), .o_com(com_a));
  fnd_sum_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .i_load(i_load), .i_sum(i_sum), .i_carry(i_carry),
    .i_en(i_en), .o_seg(seg_b), .o_dp(dp_b), .o_com(com_b));
  fnd_sum_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)) dut_c (
    .clk(clk), .reset(reset), .i_load(i_load), .i_sum(i_sum), .i_carry(i_carry),
    .i_en(i_en), .o_seg(seg_c), .o_dp(dp_c), .o_com(com_c));

  typedef struct {
    logic [6:0] sa, sb, sc;
    logic [3:0] ca, cb, cc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n     = 0;   // clock edges since the last reset release
  int   cur   = 0;   // value the display should currently hold

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic pat(input int idx, input int v, input bit en, input bit lz, input bit al,
                     output logic [6:0] seg, output logic [3:0] com);
    seg = 7'b1111111;
    com = 4'b1111;
    if (en && idx == 0) begin
      seg = glyph(v % 10);
      com = 4'b1110;
    end else if (en && idx == 1 && !(lz && (v / 10) == 0)) begin
      seg = glyph(v / 10);
      com = 4'b1101;
    end
    if (!al) begin
      seg = ~seg;
      com = ~com;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_seg_a"}, 32'(seg_a), 32'h7f);
    chk({tag, "_com_a"}, 32'(com_a), 32'hf);
    chk({tag, "_dp_a"},  32'(dp_a),  32'h1);
    chk({tag, "_seg_b"}, 32'(seg_b), 32'h7f);
    chk({tag, "_com_b"}, 32'(com_b), 32'hf);
    chk({tag, "_seg_c"}, 32'(seg_c), 32'h0);
    chk({tag, "_com_c"}, 32'(com_c), 32'h0);
    chk({tag, "_dp_c"},  32'(dp_c),  32'h0);
  endtask

  // One clock: drive inputs, push what the next edge must produce, then pop and compare.
  task automatic step(input bit ld, input logic [4:0] v, input bit en);
    exp_t e;
    exp_t g;
    int   idx;
    i_load  = ld;
    i_carry = v[4];
    i_sum   = v[3:0];
    i_en    = en;
    idx = (n / SD) % 4;
    pat(idx, cur, en, 1'b1, 1'b1, e.sa, e.ca);
    pat(idx, cur, en, 1'b0, 1'b1, e.sb, e.cb);
    pat(idx, cur, en, 1'b1, 1'b0, e.sc, e.cc);
    sb_q.push_back(e);
    @(posedge clk);
    if (ld) cur = int'(v);
    n++;
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      g = sb_q.pop_front();
      chk("seg_a", 32'(seg_a), 32'(g.sa));
      chk("com_a", 32'(com_a), 32'(g.ca));
      chk("seg_b", 32'(seg_b), 32'(g.sb));
      chk("com_b", 32'(com_b), 32'(g.cb));
      chk("seg_c", 32'(seg_c), 32'(g.sc));
      chk("com_c", 32'(com_c), 32'(g.cc));
      chk("dp_a",  32'(dp_a),  32'h1);
      chk("dp_c",  32'(dp_c),  32'h0);
      chk("onehot_a", 32'($countones(~com_a) <= 1), 32'h1);
      chk("onehot_c", 32'($countones(com_c) <= 1), 32'h1);
    end
  endtask

  task automatic step_until(input int phase);
    while ((n % (4 * SD)) != phase) step(1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    i_load  = 1'b0;
    i_sum   = 4'd0;
    i_carry = 1'b0;
    i_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_chk("reset_init");
    reset = 1'b0;
    n = 0;
    cur = 0;

    // 25: ones 5, tens 2, slots 2-3 dark, slot 0 exactly SD cycles
    step(1'b1, 5'd25, 1'b1);
    repeat (20) step(1'b0, 5'd0, 1'b1);

    // 7: tens blanked on a, shown as 0 on b
    step_until(1);
    step(1'b1, 5'd7, 1'b1);
    repeat (16) step(1'b0, 5'd0, 1'b1);

    // extremes, loaded during slot 0 to see the one-edge latency
    step_until(1);
    step(1'b1, 5'd31, 1'b1);
    repeat (16) step(1'b0, 5'd0, 1'b1);
    step_until(1);
    step(1'b1, 5'd0, 1'b1);
    repeat (16) step(1'b0, 5'd0, 1'b1);

    // load on the same edge as the 0 -> 1 index change
    step_until(3);
    step(1'b1, 5'd12, 1'b1);
    repeat (4) step(1'b0, 5'd0, 1'b1);

    // display disabled for 3 cycles while the scan keeps going
    repeat (3) step(1'b0, 5'd0, 1'b0);
    repeat (12) step(1'b0, 5'd0, 1'b1);

    // 8 on the active-high instance
    step_until(1);
    step(1'b1, 5'd8, 1'b1);
    repeat (16) step(1'b0, 5'd0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0));
    end

    // asynchronous reset in the middle of an active slot
    step_until(1);
    step(1'b1, 5'd19, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    rst_chk("reset_async");
    @(posedge clk);
    #1;
    rst_chk("reset_held");
    reset = 1'b0;
    n = 0;
    cur = 0;
    step(1'b1, 5'd25, 1'b1);
    repeat (8) step(1'b0, 5'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
